cm_sync_counter_n: RTL and testbench
====================================

Name: cm_sync_counter_n

Overview:
- Parametrised successor of the 4-bit synchronous load/count cell: an N-bit registered up/down counter.
- Provides synchronous clear, parallel load, 74x163-style dual enables (enp/ent) and programmable modulus.
- Ripple-carry output for cascading, plus a registered wrap pulse.
- Sits in the mapper regression set as a sequential benchmark and as a reusable cascadable counter slice.

Parameters:
WIDTH, 4, counter width in bits (>=2).
MODULUS, 16, count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH.
UPDOWN, 1, 1 = dir_pad honoured; 0 = dir_pad ignored, count up only.

Ports:
clk_pad  input  1  single clock, rising edge.
rst_pad  input  1  synchronous active-high reset.
clr_pad  input  1  synchronous clear, active-high.
load_pad  input  1  synchronous parallel load, active-high.
enp_pad  input  1  count enable P.
ent_pad  input  1  count enable T; also gates rco_pad.
dir_pad  input  1  1 = up, 0 = down.
d_pad  input  WIDTH  parallel load data.
q_pad  output  WIDTH  registered count.
rco_pad  output  1  combinational ripple carry out.
wrap_pad  output  1  registered one-cycle pulse after a wrap.

Behaviour:
- Reset: rst_pad high at a rising edge sets q_pad=0 and wrap_pad=0. rst_pad overrides all other inputs. While rst_pad is held, rco_pad follows its equation on q_pad=0.
- Priority per edge, highest first: rst_pad > clr_pad > load_pad > count > hold.
- clr_pad: q_pad <= 0 on the next edge. wrap_pad <= 0.
- load_pad:
  - q_pad <= d_pad when d_pad < MODULUS.
  - Otherwise q_pad <= d_pad mod MODULUS, computed as d_pad - MODULUS when d_pad >= MODULUS, repeated while still >= MODULUS. A constant-bounded loop is acceptable.
  - wrap_pad <= 0.
- Count condition: enp_pad & ent_pad.
  - Up: q_pad==MODULUS-1 -> 0, else q_pad+1.
  - Down: q_pad==0 -> MODULUS-1, else q_pad-1.
  - Arithmetic is WIDTH bits, unsigned. No intermediate overflow is permitted; wrap is by compare, never by natural rollover, unless MODULUS==2**WIDTH (then both forms agree).
- Hold: neither enable set, or either enable low -> q_pad unchanged. wrap_pad <= 0.
- Terminal count: tc = (effective_dir ? q_pad==MODULUS-1 : q_pad==0). effective_dir = UPDOWN ? dir_pad : 1.
- rco_pad = ent_pad & tc. It is combinational from registered q_pad and the ent/dir inputs; enp_pad does not affect it (cascading rule).
- wrap_pad <= 1 on exactly the edges where a count step wraps (tc & enp_pad & ent_pad, no clr/load/rst). Otherwise 0. Latency: high during the cycle after the wrapping edge.
- Direction change mid-count takes effect on the next edge. No pipeline; single-cycle latency for all ops.
- Reset or clear mid-count discards the count. A pending wrap pulse is suppressed on that edge.
- Simultaneous clr_pad & load_pad: clear wins. Simultaneous load_pad & count enables: load wins, no wrap_pad.
- Cascading: slice k enp_pad = global enable, ent_pad = rco_pad of slice k-1. The chain must count as one WIDTH*k-bit counter when MODULUS==2**WIDTH.

Decomposition:
- Package cm_counter_pkg:
  - op enum {OP_RESET, OP_CLEAR, OP_LOAD, OP_COUNT, OP_HOLD};
  - function clamp_mod(d, MODULUS);
  - localparam-derived max value MODULUS-1 with a width check (elaboration error if MODULUS > 2**WIDTH or < 2).
- One sub-module: cm_tc_detect. Inputs q, dir, ent; outputs tc and rco. It is shared combinational terminal-count logic, reused by the top counter and by the cascade test harness.

Test Plan:
- Reset/clear: WIDTH=4, MODULUS=16, count to q=7, assert clr_pad one cycle -> q_pad=0 next edge, wrap_pad=0. Assert rst_pad during load_pad=1, d=9 -> q_pad=0.
- Up wrap: MODULUS=10, load 8, enp=ent=1, dir=1 -> q: 8,9,0,1. rco_pad=1 only while q=9. wrap_pad=1 only in the cycle q=0.
- Down wrap and dir switch: MODULUS=10, load 1, dir=0 -> q: 1,0,9,8. rco_pad=1 at q=0. Flip dir=1 at q=8 -> next q=9.
- Enable gating: q=15, MODULUS=16, ent=1, enp=0 -> q holds 15, rco_pad=1, wrap_pad=0. ent=0 -> rco_pad=0.
- Load priority/clamp: MODULUS=10, d_pad=13, load_pad=1 with enp=ent=1 -> q_pad=3, wrap_pad=0. clr_pad=1 with load_pad=1 -> q_pad=0.
- Cascade: two WIDTH=4, MODULUS=16 slices chained, global enable held 256 cycles from 0 -> combined {hi,lo} steps 0..255 then 0. The hi-slice wrap_pad pulses exactly once.

Source files
------------

// File: rtl/cm_counter_pkg.sv
// Shared types and helpers for the cm_sync_counter_n counter slice.
package cm_counter_pkg;

    // Operation selected on a given clock edge, highest priority first.
    typedef enum logic [2:0] {
        OP_RESET,
        OP_CLEAR,
        OP_LOAD,
        OP_COUNT,
        OP_HOLD
    } op_e;

    // Legal parameter space: WIDTH 2..31, 2 <= MODULUS <= 2**WIDTH.
    function automatic bit mod_params_ok(input int width, input longint modulus);
        return (width >= 2) && (width <= 31) && (modulus >= 2) &&
               (modulus <= (longint'(1) << width));
    endfunction

    // d mod m as a fixed 32-step restoring remainder. The result is the same
    // as subtracting m while the value is still >= m, but the loop bound is a
    // constant and independent of how large d is relative to m.
    function automatic logic [31:0] clamp_mod(input logic [31:0] d, input logic [31:0] m);
        logic [32:0] rem;
        rem = '0;
        for (int i = 31; i >= 0; i--) begin
            rem = {rem[31:0], d[i]};
            if (rem >= {1'b0, m}) begin
                rem = rem - {1'b0, m};
            end
        end
        return rem[31:0];
    endfunction

endpackage

// File: rtl/cm_sync_counter_n_tc_detect.sv
// Terminal-count and ripple-carry detection for one counter slice.
module cm_tc_detect #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic [WIDTH-1:0] q,
    input  logic             dir,
    input  logic             ent,
    output logic             tc,
    output logic             rco
);
    import cm_counter_pkg::*;

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    // Terminal count is the last value before a wrap in the active direction.
    always_comb begin
        tc  = dir ? (q == MAX_VAL) : (q == '0);
        rco = ent & tc;
    end

endmodule

// File: rtl/cm_sync_counter_n.sv
// N-bit modulus up/down counter with clear, load, dual enables, ripple carry
// and a registered wrap pulse. Cascadable via ent_pad <= rco_pad of the
// previous slice.
module cm_sync_counter_n #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16,
    parameter int UPDOWN  = 1
) (
    input  logic             clk_pad,
    input  logic             rst_pad,
    input  logic             clr_pad,
    input  logic             load_pad,
    input  logic             enp_pad,
    input  logic             ent_pad,
    input  logic             dir_pad,
    input  logic [WIDTH-1:0] d_pad,
    output logic [WIDTH-1:0] q_pad,
    output logic             rco_pad,
    output logic             wrap_pad
);
    import cm_counter_pkg::*;

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    if (!mod_params_ok(WIDTH, MODULUS)) begin : g_bad_params
        $error("cm_sync_counter_n: illegal WIDTH/MODULUS combination");
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             dir_eff;
    logic             tc;
    op_e              op;

    assign dir_eff = (UPDOWN != 0) ? dir_pad : 1'b1;

    cm_tc_detect #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_tc_detect (
        .q   (q_q),
        .dir (dir_eff),
        .ent (ent_pad),
        .tc  (tc),
        .rco (rco_pad)
    );

    // Resolve the edge's operation by priority, then compute next count/wrap.
    always_comb begin
        op     = OP_HOLD;
        q_d    = q_q;
        wrap_d = 1'b0;
        if (rst_pad) begin
            op = OP_RESET;
        end else if (clr_pad) begin
            op = OP_CLEAR;
        end else if (load_pad) begin
            op = OP_LOAD;
        end else if (enp_pad && ent_pad) begin
            op = OP_COUNT;
        end
        case (op)
            OP_RESET, OP_CLEAR: q_d = '0;
            OP_LOAD:  q_d = WIDTH'(clamp_mod(32'(d_pad), 32'(MODULUS)));
            OP_COUNT: begin
                // Wrap by compare against the terminal value, never by rollover.
                if (dir_eff) begin
                    q_d = tc ? '0 : q_q + 1'b1;
                end else begin
                    q_d = tc ? MAX_VAL : q_q - 1'b1;
                end
                wrap_d = tc;
            end
            default: q_d = q_q;
        endcase
    end

    // Count and wrap registers with synchronous reset.
    always_ff @(posedge clk_pad) begin
        if (rst_pad) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q_pad    = q_q;
    assign wrap_pad = wrap_q;

endmodule

// File: tb/tb_cm_sync_counter_n.sv
// Directed bench for cm_sync_counter_n: a MODULUS=16 slice, a MODULUS=10
// slice, and a two-slice cascade (lo slice doubles as the cascade low half).
module tb_cm_sync_counter_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // MODULUS=10 slice
    logic       a_rst, a_clr, a_load, a_enp, a_ent, a_dir;
    logic [3:0] a_d, a_q;
    logic       a_rco, a_wrap;

    // MODULUS=16 slices (lo also used standalone)
    logic       l_rst, l_clr, l_load, l_enp, l_ent, l_dir;
    logic [3:0] l_d, l_q;
    logic       l_rco, l_wrap;
    logic       h_rst, h_enp;
    logic [3:0] h_q;
    logic       h_rco, h_wrap;

    cm_sync_counter_n #(.WIDTH(4), .MODULUS(10), .UPDOWN(1)) u_m10 (
        .clk_pad(clk), .rst_pad(a_rst), .clr_pad(a_clr), .load_pad(a_load),
        .enp_pad(a_enp), .ent_pad(a_ent), .dir_pad(a_dir), .d_pad(a_d),
        .q_pad(a_q), .rco_pad(a_rco), .wrap_pad(a_wrap));

    cm_sync_counter_n #(.WIDTH(4), .MODULUS(16), .UPDOWN(1)) u_lo (
        .clk_pad(clk), .rst_pad(l_rst), .clr_pad(l_clr), .load_pad(l_load),
        .enp_pad(l_enp), .ent_pad(l_ent), .dir_pad(l_dir), .d_pad(l_d),
        .q_pad(l_q), .rco_pad(l_rco), .wrap_pad(l_wrap));

    cm_sync_counter_n #(.WIDTH(4), .MODULUS(16), .UPDOWN(1)) u_hi (
        .clk_pad(clk), .rst_pad(h_rst), .clr_pad(1'b0), .load_pad(1'b0),
        .enp_pad(h_enp), .ent_pad(l_rco), .dir_pad(1'b1), .d_pad(4'd0),
        .q_pad(h_q), .rco_pad(h_rco), .wrap_pad(h_wrap));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int h_wraps;

    initial begin
        a_rst = 1; a_clr = 0; a_load = 0; a_enp = 0; a_ent = 0; a_dir = 1; a_d = 0;
        l_rst = 1; l_clr = 0; l_load = 0; l_enp = 0; l_ent = 0; l_dir = 1; l_d = 0;
        h_rst = 1; h_enp = 0;
        tick();
        chk("rst_q", 32'(l_q), 0);
        chk("rst_wrap", 32'(l_wrap), 0);
        chk("rst_rco_ent0", 32'(l_rco), 0);
        // rco follows its equation on q=0 while reset is held
        l_ent = 1; l_dir = 0; #1;
        chk("rst_rco_down", 32'(l_rco), 1);
        l_dir = 1; #1;
        chk("rst_rco_up", 32'(l_rco), 0);

        // ---- reset / clear on M16 ----
        l_rst = 0; l_enp = 1; l_ent = 1; l_dir = 1;
        repeat (7) tick();
        chk("cnt_to_7", 32'(l_q), 7);
        l_clr = 1; tick(); l_clr = 0;
        chk("clr_q", 32'(l_q), 0);
        chk("clr_wrap", 32'(l_wrap), 0);
        l_rst = 1; l_load = 1; l_d = 9; tick();
        chk("rst_over_load", 32'(l_q), 0);
        l_rst = 0;

        // ---- enable gating on M16 ----
        l_enp = 0; l_ent = 0; l_d = 15; tick(); l_load = 0;
        chk("load15", 32'(l_q), 15);
        l_ent = 1; l_enp = 0; l_dir = 1; tick();
        chk("gate_hold", 32'(l_q), 15);
        chk("gate_rco", 32'(l_rco), 1);
        chk("gate_wrap", 32'(l_wrap), 0);
        l_ent = 0; #1;
        chk("gate_rco_ent0", 32'(l_rco), 0);
        l_ent = 1; l_dir = 0; #1;
        chk("rco_down_at15", 32'(l_rco), 0);
        l_dir = 1; l_enp = 1; tick();
        chk("m16_natural_wrap_q", 32'(l_q), 0);
        chk("m16_wrap", 32'(l_wrap), 1);

        // ---- up wrap on M10 ----
        a_rst = 0; a_load = 1; a_d = 8; a_enp = 1; a_ent = 1; a_dir = 1; tick();
        a_load = 0;
        chk("up_q8", 32'(a_q), 8);
        chk("up_q8_rco", 32'(a_rco), 0);
        chk("up_q8_wrap", 32'(a_wrap), 0);
        tick();
        chk("up_q9", 32'(a_q), 9);
        chk("up_q9_rco", 32'(a_rco), 1);
        chk("up_q9_wrap", 32'(a_wrap), 0);
        tick();
        chk("up_q0", 32'(a_q), 0);
        chk("up_q0_rco", 32'(a_rco), 0);
        chk("up_q0_wrap", 32'(a_wrap), 1);
        tick();
        chk("up_q1", 32'(a_q), 1);
        chk("up_q1_wrap", 32'(a_wrap), 0);

        // ---- down wrap and direction switch on M10 ----
        a_load = 1; a_d = 1; a_dir = 0; tick(); a_load = 0;
        chk("dn_q1", 32'(a_q), 1);
        chk("dn_q1_rco", 32'(a_rco), 0);
        tick();
        chk("dn_q0", 32'(a_q), 0);
        chk("dn_q0_rco", 32'(a_rco), 1);
        chk("dn_q0_wrap", 32'(a_wrap), 0);
        tick();
        chk("dn_q9", 32'(a_q), 9);
        chk("dn_q9_wrap", 32'(a_wrap), 1);
        chk("dn_q9_rco", 32'(a_rco), 0);
        tick();
        chk("dn_q8", 32'(a_q), 8);
        chk("dn_q8_wrap", 32'(a_wrap), 0);
        a_dir = 1; tick();
        chk("flip_q9", 32'(a_q), 9);
        chk("flip_rco", 32'(a_rco), 1);

        // ---- load clamp / priority on M10 ----
        a_load = 1; a_d = 13; tick();
        chk("clamp13", 32'(a_q), 3);
        chk("clamp13_wrap", 32'(a_wrap), 0);
        a_d = 15; tick();
        chk("clamp15", 32'(a_q), 5);
        a_d = 9; tick();
        chk("load9_wrap", 32'(a_wrap), 0);
        a_clr = 1; a_d = 5; tick();
        chk("clr_over_load", 32'(a_q), 0);
        chk("clr_suppress_wrap", 32'(a_wrap), 0);
        a_clr = 0; a_load = 0; a_enp = 0;

        // ---- cascade: two M16 slices, 256 counts ----
        l_rst = 1; h_rst = 1; l_enp = 0; l_ent = 1; l_dir = 1; tick();
        l_rst = 0; h_rst = 0;
        chk("casc_start", 32'({h_q, l_q}), 0);
        l_enp = 1; h_enp = 1;
        h_wraps = 0;
        for (int i = 1; i <= 256; i++) begin
            tick();
            chk("casc_value", 32'({h_q, l_q}), 32'(i % 256));
            if (h_wrap) h_wraps++;
        end
        chk("casc_hi_wraps", 32'(h_wraps), 1);
        l_enp = 0; h_enp = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
